// File: rtl/vertex_buffer_loader.sv
// -----------------------------------------------------------------------------
// vertex_buffer_loader
//
// Copies a block of words from an external ROM into an internal RAM. The RAM
// then serves NUM_RD words at consecutive addresses per read.
//
// A load is requested with start. It reads ROM[src_base + i] and writes it to
// RAM[dst_base + i] for i = 0 .. length-1. Both address sequences wrap modulo
// DEPTH. The ROM answers ROM_LATENCY cycles after an address is presented. The
// write pipeline carries each destination address alongside its ROM request,
// so every write lands exactly when its data arrives.
//
// Optional feature: define VERTEX_LOADER_CHECKSUM_EN to add a `checksum`
// output. It is the running XOR of every word written during the current load.
//
// Ports
//   clk                    single rising-edge clock
//   reset                  synchronous, active-low
//   start                  load request, honoured only in IDLE
//   src_base, dst_base     ROM / RAM start word addresses
//   length                 word count 0..DEPTH; a larger value is rejected
//                          with an err pulse
//   rom_addr / rom_data    external ROM interface (rom_addr = 0 when not
//                          fetching)
//   busy                   high in FETCH, DRAIN and DONE
//   done                   one-cycle pulse when a load completes
//   ready                  RAM contents valid; cleared when a load is accepted
//   err                    one-cycle pulse for a rejected request
//   rd_addr / rd_data      registered read; slice k = RAM[rd_addr + k]; the
//                          output is zero while ready = 0
//   checksum               (VERTEX_LOADER_CHECKSUM_EN only) XOR of the loaded
//                          words
// -----------------------------------------------------------------------------
module vertex_buffer_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int NUM_RD      = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        src_base,
  input  logic [ADDR_WIDTH-1:0]        dst_base,
  input  logic [ADDR_WIDTH:0]          length,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_data,
  output logic                         busy,
  output logic                         done,
  output logic                         ready,
  output logic                         err,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data
`ifdef VERTEX_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]        checksum
`endif
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  // Last value of the drain counter. It is only used when ROM_LATENCY >= 1.
  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   src_reg, src_next;
  logic [ADDR_WIDTH-1:0]   dst_reg, dst_next;
  logic [LEN_W-1:0]        len_reg, len_next;
  logic [LEN_W-1:0]        idx_reg, idx_next;
  logic [1:0]              drain_reg, drain_next;
  logic                    ready_reg, ready_next;
  logic                    err_reg, err_next;
  logic                    accept;
  logic                    fetch_active;
  logic [ADDR_WIDTH-1:0]   fetch_dst;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      drain_reg <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      drain_reg <= drain_next;
      ready_reg <= ready_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    src_next     = src_reg;
    dst_next     = dst_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    drain_next   = drain_reg;
    ready_next   = ready_reg;
    err_next     = 1'b0;
    accept       = 1'b0;
    fetch_active = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (length > DEPTH_L) begin
            err_next = 1'b1;
          end else begin
            accept     = 1'b1;
            src_next   = src_base;
            dst_next   = dst_base;
            len_next   = length;
            idx_next   = '0;
            ready_next = 1'b0;
            // An empty load has no fetch cycles, so it completes immediately.
            if (length == '0) begin
              state_next = DONE;
              ready_next = 1'b1;
            end else begin
              state_next = FETCH;
            end
          end
        end
      end

      FETCH: begin
        fetch_active = 1'b1;
        idx_next     = idx_reg + ONE_L;
        if (idx_reg + ONE_L == len_reg) begin
          drain_next = '0;
          if (ROM_LATENCY == 0) begin
            // The last write happens in this cycle, so the RAM is valid
            // when DONE begins.
            state_next = DONE;
            ready_next = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        drain_next = drain_reg + 2'd1;
        // The last write commits on the edge that leaves this state.
        if (drain_reg == DRAIN_LAST) begin
          state_next = DONE;
          ready_next = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign ready     = ready_reg;
  assign err       = err_reg;
  assign rom_addr  = fetch_active ? (src_reg + idx_reg[ADDR_WIDTH-1:0]) : '0;
  assign fetch_dst = dst_reg + idx_reg[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Write pipeline: it matches the ROM latency so that each destination
  // address meets its data.
  // ---------------------------------------------------------------------------
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;

  generate
    if (ROM_LATENCY == 0) begin : g_direct
      assign wr_valid = fetch_active;
      assign wr_addr  = fetch_dst;
    end else begin : g_pipe
      logic [ROM_LATENCY-1:0] pipe_valid_reg;
      logic [ADDR_WIDTH-1:0]  pipe_addr_reg [ROM_LATENCY];

      // A reset drops every pending write by clearing the valid flags. The
      // address stages need no reset.
      always_ff @(posedge clk) begin
        if (!reset) begin
          pipe_valid_reg <= '0;
        end else begin
          pipe_valid_reg[0] <= fetch_active;
          for (int k = 1; k < ROM_LATENCY; k++) begin
            pipe_valid_reg[k] <= pipe_valid_reg[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        pipe_addr_reg[0] <= fetch_dst;
        for (int k = 1; k < ROM_LATENCY; k++) begin
          pipe_addr_reg[k] <= pipe_addr_reg[k-1];
        end
      end

      assign wr_valid = pipe_valid_reg[ROM_LATENCY-1];
      assign wr_addr  = pipe_addr_reg[ROM_LATENCY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Vertex RAM. It has no reset, so its contents survive a reset in the
  // middle of a load.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (reset && wr_valid) begin
      ram[wr_addr] <= rom_data;
    end
  end

  // Read ports: one registered read per slice, each at rd_addr + k. The
  // address wraps naturally in ADDR_WIDTH bits.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] word_addr;
      logic [DATA_WIDTH-1:0] word_reg;

      assign word_addr = rd_addr + ADDR_WIDTH'(gi);

      always_ff @(posedge clk) begin
        if (!reset) begin
          word_reg <= '0;
        end else begin
          word_reg <= ram[word_addr];
        end
      end

      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = ready_reg ? word_reg : '0;
    end
  endgenerate

`ifdef VERTEX_LOADER_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running XOR of the words written during the current load
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= '0;
    end else if (wr_valid) begin
      checksum_reg <= checksum_reg ^ rom_data;
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_vertex_buffer_loader.sv
module tb_vertex_buffer_loader;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 256;
  localparam int NRD = 4;
  localparam int RL  = 1;
  localparam int RP  = (RL == 0) ? 0 : RL - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [AW-1:0]       src_base = '0;
  logic [AW-1:0]       dst_base = '0;
  logic [AW:0]         length = '0;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_data;
  logic                busy, done, ready, err;
  logic [AW-1:0]       rd_addr = '0;
  logic [NRD*DW-1:0]   rd_data;
`ifdef VERTEX_LOADER_CHECKSUM_EN
  logic [DW-1:0]       checksum;
`endif

  vertex_buffer_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .NUM_RD     (NRD),
    .ROM_LATENCY(RL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .length   (length),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .ready    (ready),
    .err      (err),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`ifdef VERTEX_LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // External ROM model with a configurable latency
  logic [DW-1:0] rom [DEP];
  logic [DW-1:0] rom_pipe [4];

  always @(posedge clk) begin
    rom_pipe[0] <= rom[rom_addr];
    for (int k = 1; k < 4; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = (RL == 0) ? rom[rom_addr] : rom_pipe[RP];

  // Reference RAM model
  logic [DW-1:0] mram [DEP];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] exp;
    logic [7:0]   addr;
  } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] len;
    logic [7:0] seed;
    logic [7:0] pa;
    logic [7:0] pb;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill_rom(input logic [7:0] seed);
    for (int a = 0; a < DEP; a++) begin
      logic [7:0] b;
      b = 8'(a);
      rom[a] = {seed, b, ~b, b ^ seed};
    end
  endtask

  task automatic model_load(input logic [7:0] s, input logic [7:0] d, input int l);
    for (int i = 0; i < l; i++) begin
      logic [7:0] si, di;
      si = s + 8'(i);
      di = d + 8'(i);
      mram[di] = rom[si];
    end
  endtask

  function automatic logic [127:0] model_word4(input logic [7:0] a);
    logic [127:0] r;
    for (int k = 0; k < NRD; k++) begin
      logic [7:0] ak;
      ak = a + 8'(k);
      r[k*32 +: 32] = mram[ak];
    end
    return r;
  endfunction

  // Scoreboarded read: push the expectation when rd_addr is driven, then
  // pop and compare once the registered read data is out.
  task automatic probe(input logic [7:0] a, input logic [127:0] exp);
    rd_exp_t e;
    @(negedge clk);
    rd_addr = a;
    e.addr = a;
    e.exp = exp;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check($sformatf("rd_data@%0d", e.addr), rd_data, e.exp);
    $display("read addr=%0d data=%h", e.addr, rd_data);
  endtask

  task automatic run_load(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                          input string name);
    int cyc;
    int exp_cyc;
    @(negedge clk);
    src_base = s;
    dst_base = d;
    length = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({name, " busy"}, busy, 1'b1);
    if (l != 0) check({name, " rom_addr_first"}, rom_addr, s);
    while (cyc < 1000 && !done) begin
      @(negedge clk);
      cyc++;
    end
    exp_cyc = (l == 0) ? 1 : int'(l) + RL + 1;
    check({name, " done_cycle"}, cyc, exp_cyc);
    check({name, " ready_at_done"}, ready, 1'b1);
    @(negedge clk);
    check({name, " done_pulse_end"}, done, 1'b0);
    check({name, " rom_addr_idle"}, rom_addr, '0);
    $display("load %s src=%0d dst=%0d len=%0d done_cycle=%0d", name, s, d, l, cyc);
  endtask

  initial begin
    int cyc, ndone, dcyc, nkept;

    vecs[0] = '{src: 254, dst: 253, len: 4,  seed: 3, pa: 253, pb: 1};
    vecs[1] = '{src: 10,  dst: 100, len: 20, seed: 5, pa: 98,  pb: 118};
    vecs[2] = '{src: 200, dst: 250, len: 12, seed: 7, pa: 248, pb: 4};
    vecs[3] = '{src: 5,   dst: 0,   len: 1,  seed: 9, pa: 255, pb: 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset ready", ready, 1'b0);
    check("reset rom_addr", rom_addr, '0);
    check("reset rd_data", rd_data, '0);
    reset = 1'b1;

    // Fill the whole RAM so that every word has a known value
    fill_rom(8'h01);
    run_load(8'd0, 8'd0, 9'd256, "init_full");
    model_load(8'd0, 8'd0, 256);

    // Nominal: ROM[i] = i+1, L = 7
    for (int a = 0; a < DEP; a++) rom[a] = 32'(a + 1);
    run_load(8'd0, 8'd0, 9'd7, "nominal");
    model_load(8'd0, 8'd0, 7);
    probe(8'd0, {32'd4, 32'd3, 32'd2, 32'd1});
    probe(8'd5, model_word4(8'd5));

    // Table-driven loads, including wrap-around
    foreach (vecs[v]) begin
      fill_rom(vecs[v].seed);
      run_load(vecs[v].src, vecs[v].dst, vecs[v].len, $sformatf("vec%0d", v));
      model_load(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
      probe(vecs[v].pa, model_word4(vecs[v].pa));
      probe(vecs[v].pb, model_word4(vecs[v].pb));
    end

    // L = 0: completes in cycle 1 with no writes
    fill_rom(8'h77);
    run_load(8'd0, 8'd0, 9'd0, "len0");
    probe(8'd0, model_word4(8'd0));

    // L = 257: rejected
    @(negedge clk);
    length = 9'd257;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("oversize err", err, 1'b1);
    check("oversize busy", busy, 1'b0);
    check("oversize ready", ready, 1'b1);
    @(negedge clk);
    check("oversize err_pulse_end", err, 1'b0);
    $display("load oversize len=257 rejected");

    // Start held high through a load of L = 5
    fill_rom(8'h21);
    @(negedge clk);
    src_base = 8'd30;
    dst_base = 8'd60;
    length = 9'd5;
    start = 1'b1;
    ndone = 0;
    dcyc = 0;
    for (cyc = 1; cyc <= 5 + RL + 2; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        dcyc = cyc;
      end
    end
    check("held done_count", ndone, 1);
    check("held done_cycle", dcyc, 5 + RL + 1);
    check("held idle_gap busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("held second busy", busy, 1'b1);
    check("held second rom_addr", rom_addr, 8'd30);
    cyc = 0;
    while (cyc < 1000 && !done) begin
      @(negedge clk);
      cyc++;
    end
    check("held second done_seen", done, 1'b1);
    @(negedge clk);
    model_load(8'd30, 8'd60, 5);
    $display("load held src=30 dst=60 len=5 done_pulses_first=%0d", ndone);
    probe(8'd59, model_word4(8'd59));

    // Reset while the third FETCH cycle is in progress
    fill_rom(8'h35);
    @(negedge clk);
    src_base = 8'd40;
    dst_base = 8'd80;
    length = 9'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 1'b0);
    check("midreset ready", ready, 1'b0);
    check("midreset rd_data", rd_data, '0);
    check("midreset rom_addr", rom_addr, '0);
    reset = 1'b1;
    nkept = (RL >= 2) ? 0 : 2 - RL;
    model_load(8'd40, 8'd80, nkept);
    $display("load midreset src=40 dst=80 len=10 kept=%0d", nkept);
    run_load(8'd0, 8'd0, 9'd0, "post_reset_len0");
    probe(8'd78, model_word4(8'd78));
    probe(8'd82, model_word4(8'd82));

`ifdef VERTEX_LOADER_CHECKSUM_EN
    rom[50] = 32'h1;
    rom[51] = 32'h2;
    rom[52] = 32'h4;
    run_load(8'd50, 8'd150, 9'd3, "checksum");
    check("checksum value", checksum, 32'h7);
    model_load(8'd50, 8'd150, 3);
    probe(8'd150, model_word4(8'd150));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
